// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding and build defaults.
package fetch_unit_pkg;

  localparam int unsigned DefAddrW   = 16;
  localparam int unsigned DefResetPc = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Program memory read bus: single outstanding request, data valid with ack.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
);

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [7:0]        data;

  // Fetch unit side
  modport master (
    output req,
    output addr,
    input  ack,
    input  data
  );

  // Memory side
  modport slave (
    input  req,
    input  addr,
    output ack,
    output data
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous circular byte buffer with push/pop/flush, occupancy count and head data.
// Push and pop in the same cycle on a full buffer both take effect.
module fetch_unit_fifo #(
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [7:0]      wdata,
  output logic [7:0]      head,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  // A single-entry buffer still needs a 1-bit pointer; the spare slot is never written.
  localparam int unsigned Slots = 2 ** PtrW;

  logic [7:0]      mem_q [Slots];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Qualify requests against occupancy
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CntW'(Depth)) || do_pop);
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, reads program memory over a single-outstanding
// req/ack bus, buffers bytes and presents the head byte to the controller.
// Build option FETCH_PREFETCH_EN: DEPTH-entry prefetch buffer. Undefined: a single
// holding register (one instruction per two cycles with zero-wait memory).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  output logic [7:0]        instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  fetch_unit_if.master      mem
);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned BufDepth = DEPTH;
`else
  // Holding register only; DEPTH is legal (>= 2) so this is always 1.
  localparam int unsigned BufDepth = (DEPTH > 0) ? 1 : 0;
`endif
  localparam int unsigned CntW  = $clog2(BufDepth + 1);
  localparam int unsigned CntW1 = CntW + 1;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] faddr_q;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] pc_q;
  logic              mem_req_q;

  logic              push, pop, flush;
  logic [7:0]        head;
  logic [CntW-1:0]   count;
  logic [CntW1-1:0]  count_after;
  logic              room;

  fetch_unit_fifo #(
    .Depth (BufDepth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (mem.data),
    .head  (head),
    .count (count)
  );

  // Buffer control; a redirect beats any same-cycle push or pop
  always_comb begin
    flush       = pc_load;
    push        = (state_q == StReq) && mem.ack && !pc_load;
    pop         = fetch && instr_valid && !pc_load;
    count_after = {1'b0, count} + CntW1'(push) - CntW1'(pop);
    room        = count_after < CntW1'(BufDepth);
  end

  // Request FSM with registered bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      faddr_q   <= RESET_PC;
      target_q  <= RESET_PC;
      mem_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pc_load) begin
            faddr_q <= pc_new;
          end else if (room) begin
            state_q   <= StReq;
            mem_req_q <= 1'b1;
          end
        end
        StReq: begin
          if (pc_load) begin
            if (mem.ack) begin
              state_q   <= StIdle;
              mem_req_q <= 1'b0;
              faddr_q   <= pc_new;
            end else begin
              // Read in flight: hold the address until it completes
              state_q  <= StDrain;
              target_q <= pc_new;
            end
          end else if (mem.ack) begin
            faddr_q <= faddr_q + 1'b1;
            if (!room) begin
              state_q   <= StIdle;
              mem_req_q <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (mem.ack) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            faddr_q   <= pc_load ? pc_new : target_q;
          end else if (pc_load) begin
            target_q <= pc_new;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Head address tracks pops and redirects
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (pc_load) begin
      pc_q <= pc_new;
    end else if (pop) begin
      pc_q <= pc_q + 1'b1;
    end
  end

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head : 8'h00;
  assign pc          = pc_q;
  assign mem.req     = mem_req_q;
  assign mem.addr    = faddr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected (pc, instr) pairs, a negedge
// monitor pops and compares on every consumed instruction. Memory model returns addr[7:0]
// after a programmable number of wait cycles.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam int EffDepth     = 4;
  localparam int StreamCycles = 8;
`else
  localparam int EffDepth     = 1;
  localparam int StreamCycles = 15;
`endif

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  instr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        fetch;
  logic        pc_load;
  logic [15:0] pc_new;
  logic [7:0]  instr;
  logic        instr_valid;
  logic [15:0] pc;

  int          mem_lat;
  int          wait_cnt;
  int          n_checks;
  int          n_errors;
  int          n_pops;
  int          n_hs;
  logic [15:0] last_ack_addr;
  exp_t        exp_q [$];

  fetch_unit_if #(.ADDR_W(16)) mif ();

  fetch_unit #(
    .ADDR_W   (16),
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch       (fetch),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_load     (pc_load),
    .pc_new      (pc_new),
    .mem         (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model
  assign mif.ack  = mif.req && (wait_cnt >= mem_lat);
  assign mif.data = mif.addr[7:0];

  always @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= 0;
    else if (mif.req && !mif.ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bytes(input logic [15:0] start, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 16'(i);
      exp_q.push_back('{pc: a, instr: a[7:0]});
    end
  endtask

  task automatic wait_pops(input int target, input int bound, input string name,
                           output int cycles);
    cycles = 0;
    while (n_pops < target && cycles < bound) begin
      tick();
      cycles++;
    end
    check(name, n_pops, target);
  endtask

  task automatic wait_hs(input int target, input int bound, input string name);
    int c;
    c = 0;
    while (n_hs < target && c < bound) begin
      tick();
      c++;
    end
    check(name, n_hs, target);
  endtask

  task automatic do_reset(input int lat);
    tick();
    rst     = 1'b0;
    fetch   = 1'b0;
    pc_load = 1'b0;
    mem_lat = lat;
    tick();
    rst = 1'b1;
  endtask

  // Monitor: handshakes and consumed instructions
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mif.req && mif.ack) begin
          n_hs++;
          last_ack_addr = mif.addr;
        end
        if (fetch && instr_valid && !pc_load) begin
          n_pops++;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_pop_pc", {16'h0, pc}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", {16'h0, pc}, {16'h0, e.pc});
            check("sb_instr", {24'h0, instr}, {24'h0, e.instr});
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int cyc;
    int p0;
    int h0;
    n_checks = 0;
    n_errors = 0;
    n_pops   = 0;
    n_hs     = 0;
    last_ack_addr = '0;
    rst     = 1'b0;
    fetch   = 1'b0;
    pc_load = 1'b0;
    pc_new  = '0;
    mem_lat = 0;

    // Reset state and start-up latency, zero-wait memory
    repeat (3) tick();
    check("rst_req", mif.req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", pc, 0);
    check("rst_addr", mif.addr, 0);
    rst = 1'b1;
    tick();
    check("start_req", mif.req, 1);
    check("start_addr", mif.addr, 0);
    check("start_valid", instr_valid, 0);
    tick();
    check("valid_rise", instr_valid, 1);
    check("first_instr", instr, 8'h00);
    check("first_pc", pc, 16'h0000);

    // Streaming with fetch held high
    expect_bytes(16'h0000, 8);
    p0 = n_pops;
    fetch = 1'b1;
    wait_pops(p0 + 8, 40, "stream_pops", cyc);
    fetch = 1'b0;
    check("stream_cycles", cyc, StreamCycles);

    // Fill with fetch low, then one pop triggers exactly one request
    do_reset(0);
    h0 = n_hs;
    repeat (8) tick();
    check("fill_hs", n_hs - h0, EffDepth);
    check("fill_req_off", mif.req, 0);
    check("fill_addr", mif.addr, EffDepth);
    check("fill_valid", instr_valid, 1);
    expect_bytes(16'h0000, 1);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    repeat (5) tick();
    check("refill_hs", n_hs - h0, EffDepth + 1);
    check("refill_addr", last_ack_addr, EffDepth);
    check("refill_req_off", mif.req, 0);
    check("refill_pc", pc, 16'h0001);

    // Redirect during a slow read: old read drains, then fetch from target
    do_reset(3);
    h0 = n_hs;
    tick();
    pc_load = 1'b1;
    pc_new  = 16'h1234;
    tick();
    pc_load = 1'b0;
    check("drain_req", mif.req, 1);
    check("drain_addr_hold", mif.addr, 16'h0000);
    check("drain_pc", pc, 16'h1234);
    check("drain_valid", instr_valid, 0);
    wait_hs(h0 + 1, 10, "drain_ack");
    check("drain_ack_addr", last_ack_addr, 16'h0000);
    check("drain_discard", instr_valid, 0);
    check("drain_new_addr", mif.addr, 16'h1234);
    tick();
    check("redirect_req", mif.req, 1);
    check("redirect_addr", mif.addr, 16'h1234);
    expect_bytes(16'h1234, 2);
    p0 = n_pops;
    fetch = 1'b1;
    wait_pops(p0 + 2, 40, "redirect_pops", cyc);
    fetch = 1'b0;

    // pc_load, fetch and ack in the same cycle
    do_reset(0);
    tick();
    tick();
    p0 = n_pops;
    fetch   = 1'b1;
    pc_load = 1'b1;
    pc_new  = 16'h0800;
    tick();
    fetch   = 1'b0;
    pc_load = 1'b0;
    check("coll_valid", instr_valid, 0);
    check("coll_pc", pc, 16'h0800);
    check("coll_no_pop", n_pops, p0);
    check("coll_req_off", mif.req, 0);
    tick();
    check("coll_req", mif.req, 1);
    check("coll_addr", mif.addr, 16'h0800);

    // PC wrap-around
    pc_load = 1'b1;
    pc_new  = 16'hFFFE;
    tick();
    pc_load = 1'b0;
    check("wrap_pc_load", pc, 16'hFFFE);
    expect_bytes(16'hFFFE, 3);
    p0 = n_pops;
    fetch = 1'b1;
    wait_pops(p0 + 3, 30, "wrap_pops", cyc);
    fetch = 1'b0;
    check("wrap_pc_after", pc, 16'h0001);

    // Asynchronous reset while a request is outstanding
    repeat (8) tick();
    mem_lat = 3;
    pc_load = 1'b1;
    pc_new  = 16'h0040;
    tick();
    pc_load = 1'b0;
    check("ar_pc", pc, 16'h0040);
    tick();
    check("ar_req_pre", mif.req, 1);
    check("ar_addr_pre", mif.addr, 16'h0040);
`ifdef FETCH_PREFETCH_EN
    h0 = n_hs;
    wait_hs(h0 + 1, 10, "ar_first_ack");
    check("ar_valid_pre", instr_valid, 1);
    check("ar_instr_pre", instr, 8'h40);
    check("ar_req_next", mif.req, 1);
`endif
    #2;
    rst = 1'b0;
    #1;
    check("ar_req", mif.req, 0);
    check("ar_valid", instr_valid, 0);
    check("ar_instr", instr, 8'h00);
    check("ar_pc_reset", pc, 16'h0000);
    check("ar_addr_reset", mif.addr, 16'h0000);
    tick();
    rst = 1'b1;
    tick();

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
